// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU op codes, mul/div FSM states and EX/MEM memory-control bit indices.
package ex_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;
    localparam logic [3:0] ALU_MFHI  = 4'b1010;
    localparam logic [3:0] ALU_MFLO  = 4'b1011;

    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_t;

    // MULTU, DIVU, MFHI and MFLO share the 10xx code space
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle unsigned multiply (shift-add) / divide (restoring) with HI/LO.
module muldiv_unit
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    md_state_t   state;
    logic [5:0]  cnt;
    logic [63:0] p;
    logic [63:0] p_next;
    logic [31:0] d;
    logic [32:0] sum;
    logic [32:0] rem;
    logic [31:0] diff;
    logic        ge;

    // p holds {acc, multiplier} for MULTU and {remainder, quotient} for DIVU
    always_comb begin
        sum    = {1'b0, p[63:32]} + (p[0] ? {1'b0, d} : 33'd0);
        rem    = p[63:31];
        ge     = rem >= {1'b0, d};
        diff   = rem[31:0] - d;
        p_next = (state == MD_MUL) ? {sum, p[31:1]}
                                   : {ge ? diff : rem[31:0], p[30:0], ge};
    end

    assign busy = state != MD_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            p     <= '0;
            d     <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    state <= (op == ALU_DIVU) ? MD_DIV : MD_MUL;
                    cnt   <= '0;
                    p     <= {32'd0, a};
                    d     <= b;
                end
                MD_MUL, MD_DIV: begin
                    p   <= p_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        hi    <= p_next[63:32];
                        lo    <= p_next[31:0];
                        cnt   <= '0;
                        state <= MD_DONE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage (ALU, branch target, dest mux, EX/MEM latch);
// define MULDIV_EN to add the iterative MULTU/DIVU unit, HI/LO and its interlock.
module execute_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [1:0]        id_control_wb,
    input  logic [2:0]        id_control_mem,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_sign_ext_imm,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic              ex_flush,
    output logic              ex_stall,
    output logic              ex_valid,
    output logic [1:0]        ex_control_wb,
    output logic [2:0]        ex_mem_latch,
    output logic              ex_zero,
    output logic [DATA_W-1:0] ex_alu_result,
    output logic [DATA_W-1:0] ex_write_data,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic [DATA_W-1:0] ex_branch_target
);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] result;
    logic              take;

    assign a = id_read_data1;
    assign b = id_alu_src ? id_sign_ext_imm : id_read_data2;

`ifdef MULDIV_EN
    logic              busy;
    logic              start;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    assign ex_stall = id_valid & busy & is_muldiv(id_alu_op);
    assign start    = id_valid & ~ex_flush & ~busy
                    & (id_alu_op == ALU_MULTU | id_alu_op == ALU_DIVU);

    muldiv_unit u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (id_alu_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );
`else
    assign ex_stall = 1'b0;
`endif

    always_comb begin
        result = '0;
        case (id_alu_op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_NOR:  result = ~(a | b);
`ifdef MULDIV_EN
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
`endif
            default:  result = '0;
        endcase
    end

    // flush outranks stall; either one turns the latch into a bubble
    assign take = id_valid & ~ex_flush & ~ex_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_control_wb    <= '0;
            ex_mem_latch     <= '0;
            ex_zero          <= 1'b0;
            ex_alu_result    <= '0;
            ex_write_data    <= '0;
            ex_write_reg     <= '0;
            ex_branch_target <= '0;
        end else begin
            ex_valid         <= take;
            ex_control_wb    <= take ? id_control_wb : 2'b00;
            ex_mem_latch     <= take ? id_control_mem : 3'b000;
            ex_zero          <= result == '0;
            ex_alu_result    <= result;
            ex_write_data    <= id_read_data2;
            ex_write_reg     <= id_reg_dst ? id_rd : id_rt;
            ex_branch_target <= id_pc_plus4 + (id_sign_ext_imm << 2);
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table vectors, randomized model comparison and mul/div corner sequences.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [1:0]  id_control_wb;
    logic [2:0]  id_control_mem;
    logic [3:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic [31:0] id_read_data1;
    logic [31:0] id_read_data2;
    logic [31:0] id_sign_ext_imm;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_pc_plus4;
    logic        ex_flush;
    logic        ex_stall;
    logic        ex_valid;
    logic [1:0]  ex_control_wb;
    logic [2:0]  ex_mem_latch;
    logic        ex_zero;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic [4:0]  ex_write_reg;
    logic [31:0] ex_branch_target;

    execute_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_control_wb(id_control_wb),
        .id_control_mem(id_control_mem), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
        .id_sign_ext_imm(id_sign_ext_imm), .id_rt(id_rt), .id_rd(id_rd),
        .id_pc_plus4(id_pc_plus4), .ex_flush(ex_flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_control_wb(ex_control_wb), .ex_mem_latch(ex_mem_latch),
        .ex_zero(ex_zero), .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
        .ex_write_reg(ex_write_reg), .ex_branch_target(ex_branch_target)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference model: HI/LO, pending results and cycles of busy left
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    int          m_rem = 0;
    logic        last_stall;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        src, dst;
        logic [2:0]  mem;
        logic [4:0]  rt, rd;
        logic [31:0] pc4;
        logic [31:0] e_res;
        logic        e_zero;
        logic [4:0]  e_wreg;
        logic [31:0] e_tgt;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic apply(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic dst, input logic [1:0] wb,
                         input logic [2:0] mem, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] pc4, input logic fl);
        id_valid = v; id_alu_op = op; id_read_data1 = a; id_read_data2 = b;
        id_sign_ext_imm = imm; id_alu_src = src; id_reg_dst = dst; id_control_wb = wb;
        id_control_mem = mem; id_rt = rt; id_rd = rd; id_pc_plus4 = pc4; ex_flush = fl;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        apply(1'b1, op, a, b, 32'd0, 1'b0, 1'b1, 2'b01, 3'b000, 5'd1, 5'd2, 32'd0, 1'b0);
    endtask

    task automatic idle();
        apply(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
`ifdef MULDIV_EN
            4'b1010: return m_hi;
            4'b1011: return m_lo;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // one clock: check the combinational stall, clock, then check the EX/MEM latch against the model
    task automatic cycle();
        logic        m_stall, acc, acc_md;
        logic [31:0] bb, res, tgt;
        logic [63:0] prod;
        #2;
`ifdef MULDIV_EN
        m_stall = id_valid && m_rem > 0 && id_alu_op[3:2] == 2'b10;
        acc_md  = id_valid && !ex_flush && !m_stall && (id_alu_op == 4'b1000 || id_alu_op == 4'b1001);
`else
        m_stall = 1'b0;
        acc_md  = 1'b0;
`endif
        last_stall = ex_stall;
        chk("stall", ex_stall, m_stall);
        acc = id_valid && !ex_flush && !m_stall;
        bb  = id_alu_src ? id_sign_ext_imm : id_read_data2;
        res = ref_alu(id_alu_op, id_read_data1, bb);
        tgt = id_pc_plus4 + id_sign_ext_imm * 4;
        if (acc_md) begin
            if (id_alu_op == 4'b1000) begin
                prod  = 64'(id_read_data1) * 64'(bb);
                m_phi = prod[63:32]; m_plo = prod[31:0];
            end else if (bb == 0) begin
                m_phi = id_read_data1; m_plo = 32'hFFFFFFFF;
            end else begin
                m_phi = id_read_data1 % bb; m_plo = id_read_data1 / bb;
            end
        end
        @(posedge clk); #1;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 1) begin m_hi = m_phi; m_lo = m_plo; end
        end
        if (acc_md) m_rem = 33;
        chk("valid", ex_valid, acc);
        chk("wb", ex_control_wb, acc ? id_control_wb : 2'b00);
        chk("mem", ex_mem_latch, acc ? id_control_mem : 3'b000);
        if (acc) begin
            chk("result", ex_alu_result, res);
            chk("zero", ex_zero, res == 0);
            chk("wdata", ex_write_data, id_read_data2);
            chk("wreg", ex_write_reg, id_reg_dst ? id_rd : id_rt);
            chk("target", ex_branch_target, tgt);
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_rem = 0; m_hi = 0; m_lo = 0;
        #2;
        chk("rst_stall", ex_stall, 0);
        chk("rst_valid", ex_valid, 0);
        chk("rst_wb", ex_control_wb, 0);
        chk("rst_mem", ex_mem_latch, 0);
        chk("rst_zero", ex_zero, 0);
        chk("rst_result", ex_alu_result, 0);
        chk("rst_wdata", ex_write_data, 0);
        chk("rst_wreg", ex_write_reg, 0);
        chk("rst_target", ex_branch_target, 0);
    endtask

    // hold the current instruction until it is accepted, counting stalled cycles
    task automatic until_accept(input string nm, input int e_stalls, input logic [31:0] e_res);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (!last_stall) break;
            n++;
        end
        chk({nm, "_stalls"}, n, e_stalls);
        chk({nm, "_result"}, ex_alu_result, e_res);
    endtask

    initial begin
        logic [3:0] ops[11] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};
        tv[0]  = '{4'h2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 3'b000, 5'd2, 5'd3, 32'd0, 32'd12, 1'b0, 5'd3, 32'd0};
        tv[1]  = '{4'h6, 32'd9, 32'd9, 32'd4, 1'b0, 1'b0, 3'b100, 5'd4, 5'd5, 32'h100, 32'd0, 1'b1, 5'd4, 32'h110};
        tv[2]  = '{4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 1'b1, 3'b000, 5'd1, 5'd6, 32'd0, 32'h00F000F0, 1'b0, 5'd6, 32'd0};
        tv[3]  = '{4'h1, 32'h00001234, 32'h56780000, 32'd0, 1'b0, 1'b1, 3'b000, 5'd1, 5'd7, 32'h40, 32'h56781234, 1'b0, 5'd7, 32'h40};
        tv[4]  = '{4'h7, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 3'b000, 5'd0, 5'd8, 32'd0, 32'd1, 1'b0, 5'd8, 32'd0};
        tv[5]  = '{4'h7, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 3'b000, 5'd0, 5'd9, 32'd0, 32'd0, 1'b1, 5'd9, 32'd0};
        tv[6]  = '{4'hC, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'b000, 5'd10, 5'd11, 32'd0, 32'hFFFFFFFF, 1'b0, 5'd10, 32'd0};
        tv[7]  = '{4'h2, 32'd10, 32'h55, 32'hFFFFFFFE, 1'b1, 1'b0, 3'b010, 5'd12, 5'd13, 32'd0, 32'd8, 1'b0, 5'd12, 32'hFFFFFFF8};
        tv[8]  = '{4'h2, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 3'b000, 5'd0, 5'd14, 32'd0, 32'd0, 1'b1, 5'd14, 32'd0};
        tv[9]  = '{4'h6, 32'd0, 32'd1, 32'd0, 1'b0, 1'b1, 3'b000, 5'd0, 5'd15, 32'd0, 32'hFFFFFFFF, 1'b0, 5'd15, 32'd0};
        tv[10] = '{4'h3, 32'd123, 32'd456, 32'd0, 1'b0, 1'b1, 3'b000, 5'd0, 5'd16, 32'd0, 32'd0, 1'b1, 5'd16, 32'd0};
        tv[11] = '{4'h2, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 3'b001, 5'd17, 5'd18, 32'h100, 32'd0, 1'b1, 5'd17, 32'hFC};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            apply(1'b1, tv[i].op, tv[i].a, tv[i].b, tv[i].imm, tv[i].src, tv[i].dst, 2'b10,
                  tv[i].mem, tv[i].rt, tv[i].rd, tv[i].pc4, 1'b0);
            cycle();
            chk($sformatf("tv%0d_res", i), ex_alu_result, tv[i].e_res);
            chk($sformatf("tv%0d_zero", i), ex_zero, tv[i].e_zero);
            chk($sformatf("tv%0d_mem", i), ex_mem_latch, tv[i].mem);
            chk($sformatf("tv%0d_wreg", i), ex_write_reg, tv[i].e_wreg);
            chk($sformatf("tv%0d_tgt", i), ex_branch_target, tv[i].e_tgt);
            chk($sformatf("tv%0d_wdata", i), ex_write_data, tv[i].b);
        end

        // flushed ALU instruction leaves a bubble
        apply(1'b1, 4'h2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 2'b11, 3'b110, 5'd1, 5'd2, 32'd0, 1'b1);
        cycle();

`ifdef MULDIV_EN
        issue(4'h8, 32'hFFFFFFFF, 32'd2); cycle();
        issue(4'hA, 32'd0, 32'd0);        until_accept("mfhi_mul", 33, 32'h00000001);
        issue(4'hB, 32'd0, 32'd0);        until_accept("mflo_mul", 0, 32'hFFFFFFFE);

        issue(4'h8, 32'd3, 32'd5);        cycle();
        issue(4'h2, 32'd20, 32'd22);      until_accept("add_busy", 0, 32'd42);
        issue(4'hB, 32'd0, 32'd0);        until_accept("mflo_after_add", 32, 32'd15);

        issue(4'h9, 32'd100, 32'd7);      cycle();
        issue(4'hB, 32'd0, 32'd0);        until_accept("div_lo", 33, 32'd14);
        issue(4'hA, 32'd0, 32'd0);        until_accept("div_hi", 0, 32'd2);

        issue(4'h9, 32'd5, 32'd0);        cycle();
        issue(4'hB, 32'd0, 32'd0);        until_accept("div0_lo", 33, 32'hFFFFFFFF);
        issue(4'hA, 32'd0, 32'd0);        until_accept("div0_hi", 0, 32'd5);

        // flushed MULTU never starts the unit and HI/LO keep their values
        issue(4'h8, 32'd7, 32'd9); ex_flush = 1'b1; cycle();
        issue(4'hA, 32'd0, 32'd0);        until_accept("flush_hi", 0, 32'd5);
        issue(4'hB, 32'd0, 32'd0);        until_accept("flush_lo", 0, 32'hFFFFFFFF);

        // second MULTU while busy stalls like any dependent op
        issue(4'h8, 32'd6, 32'd7);        cycle();
        issue(4'h8, 32'd2, 32'd3);        until_accept("multu_busy", 33, 32'd0);
        issue(4'hB, 32'd0, 32'd0);        until_accept("mflo_second", 33, 32'd6);

        // reset 10 cycles into a MULTU aborts it and clears HI/LO
        issue(4'h8, 32'hDEADBEEF, 32'h12345); cycle();
        idle();
        for (int i = 0; i < 10; i++) cycle();
        do_reset();
        issue(4'hA, 32'd0, 32'd0);        until_accept("rst_mfhi", 0, 32'd0);
        issue(4'hB, 32'd0, 32'd0);        until_accept("rst_mflo", 0, 32'd0);
`else
        issue(4'h8, 32'hFFFFFFFF, 32'd2); until_accept("multu_off", 0, 32'd0);
        issue(4'hA, 32'd0, 32'd0);        until_accept("mfhi_off", 0, 32'd0);
        issue(4'hB, 32'd0, 32'd0);        until_accept("mflo_off", 0, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b, imm;
            logic        src;
            op = ops[$urandom_range(0, 10)];
            if (op[3:2] == 2'b10 && $urandom_range(0, 3) != 0) op = 4'h2;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : 32'($urandom_range(0, 40));
            src = (op[3:2] == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) idle();
            else apply(1'b1, op, a, b, imm, src, 1'($urandom), 2'($urandom), 3'($urandom),
                       5'($urandom), 5'($urandom), $urandom, $urandom_range(0, 9) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
